fp_mul_pipe: RTL and testbench
==============================

Name: fp_mul_pipe

Overview:
- Parametrised, 3-stage pipelined IEEE-754 binary floating-point multiplier with valid/ready handshakes on input and output.
- Successor to the team's combinational single-precision multiplier. Adds:
  - configurable exponent and mantissa widths;
  - round-to-nearest-even;
  - special-value handling (zero, inf, NaN, overflow, underflow);
  - backpressure.
- Sits between the sensor-data datapath and downstream accumulators.

Parameters:
- EXP_W, 8, exponent field width in bits.
- MAN_W, 23, stored mantissa (fraction) width in bits. Total word W = 1+EXP_W+MAN_W.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  operands present on a_in/b_in.
- in_ready  out  1  block accepts operands this cycle.
- a_in  in  W  operand A: sign, exponent, fraction.
- b_in  in  W  operand B.
- out_valid  out  1  result present on out_data.
- out_ready  in  1  consumer accepts result this cycle.
- out_data  out  W  product, IEEE format.
- flags  out  4  {invalid, overflow, underflow, inexact}. Present only with FP_MUL_FLAGS_EN.

Behaviour:
- Reset (asynchronous, immediate): all stage valid bits=0, out_valid=0, out_data=0, flags=0. In-flight operations are discarded. in_ready=1 after reset.
- Pipeline enable: en = !out_valid || out_ready. The whole pipe advances only when en=1. in_ready = en, combinational.
- Transfers:
  - Input transfer: in_valid && in_ready.
  - Output transfer: out_valid && out_ready.
  - out_data/flags hold stable while out_valid=1 and out_ready=0.
- Latency: 3 cycles from input transfer to out_valid with out_ready held high. Throughput 1 op/cycle.
- Bubbles propagate as invalid stages; a bubble does not stall the pipe.
- S1, decode:
  - sign = sa^sb.
  - Classify each operand:
    - zero: exp=0 (subnormals flushed to zero);
    - inf: exp all ones, frac=0;
    - NaN: exp all ones, frac!=0;
    - normal otherwise.
  - Exponent sum e = ea+eb-bias, with bias=2^(EXP_W-1)-1, held signed in EXP_W+2 bits.
  - Significands get the hidden 1 prepended.
- S2, multiply: (MAN_W+1)x(MAN_W+1) unsigned product, 2*MAN_W+2 bits.
- S3, normalise and round:
  - If the product MSB is set, shift right 1 and e+=1.
  - Guard = first dropped bit; sticky = OR of the remaining dropped bits.
  - Round to nearest, ties to even.
  - A rounding carry-out renormalises and e+=1.
- Results, in priority order:
  - Any NaN operand, or inf×zero: canonical qNaN {0, all ones, 1, zeros}. invalid=1 for inf×zero and for signalling NaN.
  - inf × (inf or normal): signed inf.
  - zero × finite: signed zero.
  - e >= 2^EXP_W-1 after rounding: signed inf; overflow=1, inexact=1.
  - e <= 0: signed zero (flush-to-zero); underflow=1, inexact=1.
  - Otherwise: {sign, e[EXP_W-1:0], rounded fraction}; inexact = guard|sticky.
- Simultaneous input and output transfer in the same cycle is legal and keeps full throughput.

Optional Feature:
- Macro FP_MUL_FLAGS_EN.
- Defined: the flags port exists and is registered in S3 alongside out_data, with the same hold rules.
- Undefined: no flags port and no flag logic; result values are identical.

Decomposition:
- Package fp_mul_pkg:
  - operand class enum {ZERO, NORM, INF, NAN};
  - bias and quiet-NaN constant functions of EXP_W/MAN_W;
  - flag bit index constants.
- Sub-module fp_round_norm: combinational S3 normalise/round/exception logic, instantiated once.

Test Plan:
- Basic, single precision: 0x40000000×0x40400000 -> 0x40C00000 (2×3=6) after 3 cycles. 0x3FC00000×0x3FC00000 -> 0x40100000.
- Rounding: 0x3F800001×0x3F800001 -> 0x3F800002, inexact=1. 0xC0000000×0x00000000 -> 0x80000000.
- Specials:
  - 0x7F800000×0x00000000 -> 0x7FC00000, invalid=1.
  - 0x7F800000×0xBF800000 -> 0xFF800000.
  - 0x7FC00001×0x3F800000 -> 0x7FC00000.
- Range:
  - 0x7F000000×0x40000000 -> 0x7F800000, overflow=1.
  - 0x00800000×0x3F000000 -> 0x00000000, underflow=1.
- Backpressure: hold out_ready=0 and offer 4 ops. Expect:
  - 3 ops accepted, then in_ready=0;
  - out_data stable while stalled.
  - Then release out_ready: 4 results in order on consecutive cycles.
- Reset mid-flight: assert rst with 2 ops in flight. out_valid=0 immediately, no stale results after rst drops, in_ready=1.

Source files
------------

// File: rtl/fp_mul_pkg.sv
// Shared types and constants for the pipelined floating-point multiplier.
// Operand classes, exponent bias, canonical quiet NaN and flag bit positions.
package fp_mul_pkg;

  typedef enum logic [1:0] {
    ZERO,
    NORM,
    INF,
    NAN
  } opClass_t;

  localparam int FLAG_INVALID   = 3;
  localparam int FLAG_OVERFLOW  = 2;
  localparam int FLAG_UNDERFLOW = 1;
  localparam int FLAG_INEXACT   = 0;

  localparam int MAX_W = 128;

  function automatic int expBias(input int expW);
    return (1 << (expW - 1)) - 1;
  endfunction

  // Canonical qNaN: positive sign, all-ones exponent, only the fraction MSB set.
  function automatic logic [MAX_W-1:0] qnanWord(input int expW, input int manW);
    logic [MAX_W-1:0] w;
    w = '0;
    for (int i = 0; i < expW; i++) begin
      w[manW + i] = 1'b1;
    end
    w[manW - 1] = 1'b1;
    return w;
  endfunction

endpackage

// File: rtl/fp_round_norm.sv
// Combinational third stage: normalise the raw significand product, round to
// nearest-even and resolve special values. Flags exist only with FP_MUL_FLAGS_EN.
module fp_round_norm
  import fp_mul_pkg::*;
#(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic                     i_sign,
  input  opClass_t                 i_clsA,
  input  opClass_t                 i_clsB,
  input  logic signed [EXP_W+1:0]  i_exp,
  input  logic [2*MAN_W+1:0]       i_prod,
`ifdef FP_MUL_FLAGS_EN
  input  logic                     i_snan,
  output logic [3:0]               o_flags,
`endif
  output logic [EXP_W+MAN_W:0]     o_result
);

  localparam int W  = 1 + EXP_W + MAN_W;
  localparam int PW = 2 * MAN_W + 2;
  localparam logic [W-1:0] QNAN = W'(qnanWord(EXP_W, MAN_W));
  localparam logic signed [EXP_W+1:0] EXP_MAX = (EXP_W+2)'((1 << EXP_W) - 1);

  logic [PW-2:0]            w_norm;
  logic [MAN_W-1:0]         w_mant;
  logic                     w_guard;
  logic                     w_sticky;
  logic                     w_roundUp;
  logic [MAN_W:0]           w_mantRnd;
  logic signed [EXP_W+1:0]  w_expNorm;
  logic signed [EXP_W+1:0]  w_expRnd;
  logic                     w_infZero;
  logic                     w_nanCase;
  logic                     w_infCase;
  logic                     w_zeroCase;
  logic                     w_ovf;
  logic                     w_unf;

  // w_norm holds the bits below the leading one, left-aligned in either case.
  assign w_norm    = i_prod[PW-1] ? i_prod[PW-2:0] : {i_prod[PW-3:0], 1'b0};
  assign w_mant    = w_norm[PW-2:MAN_W+1];
  assign w_guard   = w_norm[MAN_W];
  assign w_sticky  = |w_norm[MAN_W-1:0];
  assign w_roundUp = w_guard & (w_sticky | w_mant[0]);
  assign w_mantRnd = {1'b0, w_mant} + (MAN_W+1)'(w_roundUp);
  assign w_expNorm = i_exp + (EXP_W+2)'(i_prod[PW-1]);
  assign w_expRnd  = w_expNorm + (EXP_W+2)'(w_mantRnd[MAN_W]);

  assign w_infZero  = ((i_clsA == INF) && (i_clsB == ZERO)) ||
                      ((i_clsA == ZERO) && (i_clsB == INF));
  assign w_nanCase  = (i_clsA == NAN) || (i_clsB == NAN) || w_infZero;
  assign w_infCase  = (i_clsA == INF) || (i_clsB == INF);
  assign w_zeroCase = (i_clsA == ZERO) || (i_clsB == ZERO);
  assign w_ovf      = w_expRnd >= EXP_MAX;
  assign w_unf      = w_expRnd[EXP_W+1] || (w_expRnd == '0);

  always_comb begin
    o_result = {i_sign, w_expRnd[EXP_W-1:0], w_mantRnd[MAN_W-1:0]};
    if (w_nanCase) begin
      o_result = QNAN;
    end else if (w_infCase || w_ovf) begin
      o_result = {i_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    end else if (w_zeroCase || w_unf) begin
      o_result = {i_sign, {(W-1){1'b0}}};
    end
  end

`ifdef FP_MUL_FLAGS_EN
  always_comb begin
    o_flags = '0;
    if (w_nanCase) begin
      o_flags[FLAG_INVALID] = i_snan | w_infZero;
    end else if (!(w_infCase || w_zeroCase)) begin
      if (w_ovf) begin
        o_flags[FLAG_OVERFLOW] = 1'b1;
        o_flags[FLAG_INEXACT]  = 1'b1;
      end else if (w_unf) begin
        o_flags[FLAG_UNDERFLOW] = 1'b1;
        o_flags[FLAG_INEXACT]   = 1'b1;
      end else begin
        o_flags[FLAG_INEXACT] = w_guard | w_sticky;
      end
    end
  end
`endif

endmodule

// File: rtl/fp_mul_pipe.sv
// 3-stage pipelined IEEE-754 multiplier (decode, multiply, normalise/round) with valid/ready.
// Define FP_MUL_FLAGS_EN to add the registered {invalid, overflow, underflow, inexact} flags port.
module fp_mul_pipe
  import fp_mul_pkg::*;
#(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [EXP_W+MAN_W:0]  a_in,
  input  logic [EXP_W+MAN_W:0]  b_in,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [EXP_W+MAN_W:0]  out_data
`ifdef FP_MUL_FLAGS_EN
  ,
  output logic [3:0]            flags
`endif
);

  localparam int W  = 1 + EXP_W + MAN_W;
  localparam int PW = 2 * MAN_W + 2;
  localparam logic [EXP_W+1:0] BIAS = (EXP_W+2)'(expBias(EXP_W));

  function automatic opClass_t classOf(input logic [EXP_W-1:0] e, input logic [MAN_W-1:0] f);
    if (e == '0) begin
      return ZERO;
    end
    if (&e) begin
      return (f == '0) ? INF : NAN;
    end
    return NORM;
  endfunction

  logic                     w_en;
  logic [EXP_W-1:0]         w_expA;
  logic [EXP_W-1:0]         w_expB;
  logic [MAN_W-1:0]         w_fracA;
  logic [MAN_W-1:0]         w_fracB;
  logic signed [EXP_W+1:0]  w_expSum;
  logic [PW-1:0]            w_prod;
  logic [W-1:0]             w_result;

  logic                     r_s1Valid;
  logic                     r_s1Sign;
  opClass_t                 r_s1ClsA;
  opClass_t                 r_s1ClsB;
  logic signed [EXP_W+1:0]  r_s1Exp;
  logic [MAN_W:0]           r_s1SigA;
  logic [MAN_W:0]           r_s1SigB;

  logic                     r_s2Valid;
  logic                     r_s2Sign;
  opClass_t                 r_s2ClsA;
  opClass_t                 r_s2ClsB;
  logic signed [EXP_W+1:0]  r_s2Exp;
  logic [PW-1:0]            r_s2Prod;

  // A full output register that nobody is taking freezes the whole pipe.
  assign w_en     = !out_valid || out_ready;
  assign in_ready = w_en;

  assign w_expA   = a_in[W-2:MAN_W];
  assign w_expB   = b_in[W-2:MAN_W];
  assign w_fracA  = a_in[MAN_W-1:0];
  assign w_fracB  = b_in[MAN_W-1:0];
  assign w_expSum = {2'b00, w_expA} + {2'b00, w_expB} - BIAS;
  assign w_prod   = PW'(r_s1SigA) * PW'(r_s1SigB);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1Valid <= 1'b0;
      r_s1Sign  <= 1'b0;
      r_s1ClsA  <= ZERO;
      r_s1ClsB  <= ZERO;
      r_s1Exp   <= '0;
      r_s1SigA  <= '0;
      r_s1SigB  <= '0;
    end else if (w_en) begin
      r_s1Valid <= in_valid;
      r_s1Sign  <= a_in[W-1] ^ b_in[W-1];
      r_s1ClsA  <= classOf(w_expA, w_fracA);
      r_s1ClsB  <= classOf(w_expB, w_fracB);
      r_s1Exp   <= w_expSum;
      r_s1SigA  <= {1'b1, w_fracA};
      r_s1SigB  <= {1'b1, w_fracB};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s2Valid <= 1'b0;
      r_s2Sign  <= 1'b0;
      r_s2ClsA  <= ZERO;
      r_s2ClsB  <= ZERO;
      r_s2Exp   <= '0;
      r_s2Prod  <= '0;
    end else if (w_en) begin
      r_s2Valid <= r_s1Valid;
      r_s2Sign  <= r_s1Sign;
      r_s2ClsA  <= r_s1ClsA;
      r_s2ClsB  <= r_s1ClsB;
      r_s2Exp   <= r_s1Exp;
      r_s2Prod  <= w_prod;
    end
  end

`ifdef FP_MUL_FLAGS_EN
  logic       r_s1Snan;
  logic       r_s2Snan;
  logic [3:0] w_flags;

  // Signalling NaN: all-ones exponent, nonzero fraction with the quiet bit clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1Snan <= 1'b0;
      r_s2Snan <= 1'b0;
    end else if (w_en) begin
      r_s1Snan <= ((&w_expA) && (w_fracA != '0) && !w_fracA[MAN_W-1]) ||
                  ((&w_expB) && (w_fracB != '0) && !w_fracB[MAN_W-1]);
      r_s2Snan <= r_s1Snan;
    end
  end
`endif

  fp_round_norm #(
    .EXP_W (EXP_W),
    .MAN_W (MAN_W)
  ) u_roundNorm (
    .i_sign   (r_s2Sign),
    .i_clsA   (r_s2ClsA),
    .i_clsB   (r_s2ClsB),
    .i_exp    (r_s2Exp),
    .i_prod   (r_s2Prod),
`ifdef FP_MUL_FLAGS_EN
    .i_snan   (r_s2Snan),
    .o_flags  (w_flags),
`endif
    .o_result (w_result)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (w_en) begin
      out_valid <= r_s2Valid;
      if (r_s2Valid) begin
        out_data <= w_result;
      end
    end
  end

`ifdef FP_MUL_FLAGS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flags <= '0;
    end else if (w_en && r_s2Valid) begin
      flags <= w_flags;
    end
  end
`endif

endmodule

// File: tb/tb_fp_mul_pipe.sv
// Self-checking bench for fp_mul_pipe (single precision): directed vectors, backpressure,
// randomized traffic against a reference model, and reset mid-flight. Honours FP_MUL_FLAGS_EN.
module tb_fp_mul_pipe;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a_in;
  logic [31:0] b_in;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
`ifdef FP_MUL_FLAGS_EN
  logic [3:0]  flags;
`endif

  int checkCount = 0;
  int errorCount = 0;
  logic [35:0] expQ[$];
  logic        holdPending = 1'b0;
  logic [31:0] holdData = '0;

  fp_mul_pipe #(
    .EXP_W (8),
    .MAN_W (23)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a_in      (a_in),
    .b_in      (b_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
`ifdef FP_MUL_FLAGS_EN
    ,
    .flags     (flags)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Reference: exact integer product, rounding decided by comparing the remainder with half an ulp.
  function automatic logic [35:0] refMul(input logic [31:0] a, input logic [31:0] b);
    int                ea, eb, e, sh;
    longint unsigned   fa, fb, p, mant, rem, half;
    bit                s, aZero, bZero, aInf, bInf, aNan, bNan, sNan, infZero;
    logic [3:0]        f;
    logic [31:0]       r;
    ea = int'(a[30:23]);
    eb = int'(b[30:23]);
    fa = longint'(a[22:0]);
    fb = longint'(b[22:0]);
    s  = a[31] ^ b[31];
    aZero = (ea == 0);
    bZero = (eb == 0);
    aInf  = (ea == 255) && (fa == 0);
    bInf  = (eb == 255) && (fb == 0);
    aNan  = (ea == 255) && (fa != 0);
    bNan  = (eb == 255) && (fb != 0);
    sNan  = (aNan && !a[22]) || (bNan && !b[22]);
    infZero = (aInf && bZero) || (bInf && aZero);
    f = 4'b0000;
    if (aNan || bNan || infZero) begin
      r = 32'h7FC00000;
      f[3] = sNan || infZero;
    end else if (aInf || bInf) begin
      r = {s, 8'hFF, 23'h0};
    end else if (aZero || bZero) begin
      r = {s, 31'h0};
    end else begin
      p    = ((64'd1 << 23) | fa) * ((64'd1 << 23) | fb);
      sh   = (p >= (64'd1 << 47)) ? 24 : 23;
      e    = ea + eb - 127 + (sh - 23);
      mant = p >> sh;
      rem  = p - (mant << sh);
      half = 64'd1 << (sh - 1);
      if (rem > half || (rem == half && mant[0])) mant++;
      if (mant == (64'd1 << 24)) begin
        mant = mant >> 1;
        e++;
      end
      if (e >= 255) begin
        r = {s, 8'hFF, 23'h0};
        f = 4'b0101;
      end else if (e <= 0) begin
        r = {s, 31'h0};
        f = 4'b0011;
      end else begin
        r = {s, e[7:0], mant[22:0]};
        f[0] = (rem != 0);
      end
    end
    return {f, r};
  endfunction

  function automatic logic [31:0] randOperand();
    logic [7:0]  e;
    logic [22:0] f;
    int sel;
    sel = $urandom_range(0, 9);
    case (sel)
      0:       e = 8'h00;
      1:       e = 8'hFF;
      2:       e = 8'($urandom_range(1, 40));
      3:       e = 8'($urandom_range(215, 254));
      default: e = 8'($urandom_range(1, 254));
    endcase
    f = ($urandom_range(0, 3) == 0) ? 23'h0 : 23'($urandom);
    return {1'($urandom), e, f};
  endfunction

  // One cycle of scoreboarded traffic; transfers are decided from values sampled after the negedge.
  task automatic applyStimulus(input logic v, input logic [31:0] a, input logic [31:0] b, input logic r);
    logic [35:0] e;
    @(negedge clk);
    in_valid  = v;
    a_in      = a;
    b_in      = b;
    out_ready = r;
    #1;
    checkOutput("in_ready_rule", in_ready, !out_valid || out_ready);
    if (holdPending) begin
      checkOutput("hold_valid", out_valid, 1);
      checkOutput("hold_data", out_data, holdData);
    end
    if (out_valid && out_ready) begin
      if (expQ.size() == 0) begin
        checkOutput("sb_extra", out_valid, 0);
      end else begin
        e = expQ.pop_front();
        checkOutput("sb_data", out_data, e[31:0]);
`ifdef FP_MUL_FLAGS_EN
        checkOutput("sb_flags", flags, e[35:32]);
`endif
      end
    end
    if (in_valid && in_ready) expQ.push_back(refMul(a, b));
    holdPending = out_valid && !out_ready;
    holdData    = out_data;
  endtask

  task automatic runDirected(input string tag, input logic [31:0] a, input logic [31:0] b,
                             input logic [31:0] expData, input logic [3:0] expF);
    int lat;
    @(negedge clk);
    in_valid  = 1'b1;
    a_in      = a;
    b_in      = b;
    out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    checkOutput({tag, "_lat"}, 64'(lat), 64'd3);
    checkOutput({tag, "_data"}, out_data, expData);
`ifdef FP_MUL_FLAGS_EN
    checkOutput({tag, "_flags"}, flags, expF);
`endif
    $display("[TB] directed %s done (expected flags %b)", tag, expF);
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not complete in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [31:0] bpA[4];
    logic [31:0] bpExp[4];
    logic [31:0] held;
    int accepted;
    logic sawValid;

    bpA   = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000};
    bpExp = '{32'h40000000, 32'h40800000, 32'h40C00000, 32'h41000000};

    rst = 1'b1; in_valid = 1'b0; a_in = '0; b_in = '0; out_ready = 1'b0;
    #2;
    checkOutput("reset_out_valid", out_valid, 0);
    checkOutput("reset_in_ready", in_ready, 1);
    checkOutput("reset_out_data", out_data, 0);
`ifdef FP_MUL_FLAGS_EN
    checkOutput("reset_flags", flags, 0);
`endif
    @(negedge clk);
    rst = 1'b0;

    runDirected("mul_2x3",     32'h40000000, 32'h40400000, 32'h40C00000, 4'b0000);
    runDirected("mul_1p5sq",   32'h3FC00000, 32'h3FC00000, 32'h40100000, 4'b0000);
    runDirected("round_inex",  32'h3F800001, 32'h3F800001, 32'h3F800002, 4'b0001);
    runDirected("round_tie",   32'h3F800001, 32'h3FC00000, 32'h3FC00002, 4'b0001);
    runDirected("neg_zero",    32'hC0000000, 32'h00000000, 32'h80000000, 4'b0000);
    runDirected("inf_x_zero",  32'h7F800000, 32'h00000000, 32'h7FC00000, 4'b1000);
    runDirected("inf_x_neg1",  32'h7F800000, 32'hBF800000, 32'hFF800000, 4'b0000);
    runDirected("qnan_in",     32'h7FC00001, 32'h3F800000, 32'h7FC00000, 4'b0000);
    runDirected("snan_in",     32'h7F800001, 32'h3F800000, 32'h7FC00000, 4'b1000);
    runDirected("overflow",    32'h7F000000, 32'h40000000, 32'h7F800000, 4'b0101);
    runDirected("underflow",   32'h00800000, 32'h3F000000, 32'h00000000, 4'b0011);

    // Backpressure: four ops offered against a stalled consumer.
    @(negedge clk);
    out_ready = 1'b0;
    accepted  = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      in_valid = (accepted < 4);
      a_in     = (accepted < 4) ? bpA[accepted] : 32'h0;
      b_in     = 32'h40000000;
      #1;
      if (in_valid && in_ready) accepted++;
    end
    checkOutput("bp_accepted", 64'(accepted), 64'd3);
    checkOutput("bp_in_ready", in_ready, 0);
    checkOutput("bp_first", out_data, bpExp[0]);
    held = out_data;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      #1;
      checkOutput("bp_hold", out_data, held);
    end
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      in_valid  = (accepted < 4);
      out_ready = 1'b1;
      #1;
      checkOutput("bp_valid", out_valid, 1);
      checkOutput("bp_order", out_data, bpExp[k]);
      if (in_valid && in_ready) accepted++;
    end
    @(negedge clk);
    in_valid = 1'b0;
    for (int c = 0; c < 4; c++) @(negedge clk);

    // Randomized traffic with random backpressure.
    holdPending = 1'b0;
    for (int c = 0; c < 2000; c++) begin
      applyStimulus(($urandom_range(0, 3) != 0), randOperand(), randOperand(), ($urandom_range(0, 9) < 7));
    end
    for (int c = 0; c < 50 && expQ.size() != 0; c++) begin
      applyStimulus(1'b0, 32'h0, 32'h0, 1'b1);
    end
    checkOutput("drain_empty", 64'(expQ.size()), 64'd0);
    holdPending = 1'b0;

    // Reset with operations in flight.
    @(negedge clk);
    out_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      in_valid = 1'b1;
      a_in     = 32'h40400000;
      b_in     = 32'h40400000;
      @(negedge clk);
    end
    in_valid = 1'b0;
    #1;
    checkOutput("rst_pre_valid", out_valid, 1);
    #1;
    rst = 1'b1;
    #1;
    checkOutput("rst_out_valid", out_valid, 0);
    checkOutput("rst_out_data", out_data, 0);
    checkOutput("rst_in_ready", in_ready, 1);
    @(negedge clk);
    rst       = 1'b0;
    out_ready = 1'b1;
    sawValid  = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      #1;
      sawValid = sawValid | out_valid;
    end
    checkOutput("rst_no_stale", sawValid, 0);
    checkOutput("rst_in_ready_after", in_ready, 1);

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
